// File: rtl/cu_pkg.sv
// Shared decode types: control bundle layout, RV32 opcodes, ALU/immediate/result encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cu_pkg;

    // Major opcodes decoded by this core
    localparam logic [6:0] OPC_OP     = 7'd51;
    localparam logic [6:0] OPC_LOAD   = 7'd3;
    localparam logic [6:0] OPC_OP_IMM = 7'd19;
    localparam logic [6:0] OPC_STORE  = 7'd35;
    localparam logic [6:0] OPC_BRANCH = 7'd99;
    localparam logic [6:0] OPC_JALR   = 7'd103;
    localparam logic [6:0] OPC_JAL    = 7'd111;
    localparam logic [6:0] OPC_LUI    = 7'd55;
    localparam logic [6:0] OPC_AUIPC  = 7'd23;

    // funct7 groups on OPC_OP
    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    // ALU operation classes (execute refines FUNCT/MUL/DIV with funct3/funct7)
    localparam logic [2:0] ALU_OP_BR    = 3'd1;
    localparam logic [2:0] ALU_OP_FUNCT = 3'd2;
    localparam logic [2:0] ALU_OP_LUI   = 3'd3;
    localparam logic [2:0] ALU_OP_MUL   = 3'd4;
    localparam logic [2:0] ALU_OP_DIV   = 3'd5;

    // Immediate formats
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    // Writeback source select
    localparam logic [1:0] RES_MEM = 2'd1;
    localparam logic [1:0] RES_PC4 = 2'd2;

    typedef struct packed {
        logic       jump;
        logic       branch;
        logic [1:0] result_src;
        logic       mem_write;
        logic       alu_src;
        logic [2:0] imm_src;
        logic       reg_write;
        logic [2:0] alu_op;
        logic       jalr;
        logic       op1_pc;
        logic       rs1_used;
        logic       rs2_used;
        logic       mul_en;
        logic       div_en;
        logic       illegal;
    } ctrl_t;

    // True for anything that needs the M-extension datapath
    function automatic logic is_m_op(ctrl_t c);
        return c.mul_en | c.div_en;
    endfunction

endpackage

// File: rtl/decode_stage_ctrl_if.sv
// Fetch->decode->execute handshake bundle; slave = decode stage, master = surrounding pipeline.
// Latency: n/a (wiring only).
// Backpressure: in_ready/out_ready valid-ready pairs carried through unchanged.
interface decode_stage_ctrl_if
    import cu_pkg::*;
#(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [2:0]      out_funct3;
    ctrl_t           out_ctrl;
    logic            div_busy;

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2,
               out_funct3, out_ctrl, div_busy
    );

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2,
               out_funct3, out_ctrl, div_busy
    );
endinterface

// File: rtl/decode_ctrl_comb.sv
// Pure instruction -> ctrl_t decoder; illegal encodings trap when CU_ILLEGAL_TRAP_EN is defined, else become NOPs.
// Latency: combinational.
// Backpressure: none (no state).
module decode_ctrl_comb
    import cu_pkg::*;
#(
    parameter int M_EXT = 1
) (
    input  logic [31:0] instr,
    output ctrl_t       ctrl
);
    logic [6:0] opcode;
    logic [6:0] funct7;
    ctrl_t      ctrl_raw;
    logic       bad;

    assign opcode = instr[6:0];
    assign funct7 = instr[31:25];

    // Opcode table; an all-zero word is a bubble and never flagged illegal
    always_comb begin
        ctrl_raw = '0;
        bad      = 1'b0;
        case (opcode)
            OPC_OP: begin
                ctrl_raw.reg_write = 1'b1;
                ctrl_raw.rs1_used  = 1'b1;
                ctrl_raw.rs2_used  = 1'b1;
                ctrl_raw.alu_op    = ALU_OP_FUNCT;
                if (funct7 == F7_MULDIV && M_EXT != 0) begin
                    ctrl_raw.alu_op = instr[14] ? ALU_OP_DIV : ALU_OP_MUL;
                    ctrl_raw.div_en = instr[14];
                    ctrl_raw.mul_en = ~instr[14];
                end else if (funct7 != F7_BASE && funct7 != F7_ALT) begin
                    bad = 1'b1;
                end
            end
            OPC_LOAD: begin
                ctrl_raw.result_src = RES_MEM;
                ctrl_raw.alu_src    = 1'b1;
                ctrl_raw.imm_src    = IMM_I;
                ctrl_raw.reg_write  = 1'b1;
                ctrl_raw.rs1_used   = 1'b1;
            end
            OPC_OP_IMM: begin
                ctrl_raw.alu_src   = 1'b1;
                ctrl_raw.imm_src   = IMM_I;
                ctrl_raw.reg_write = 1'b1;
                ctrl_raw.alu_op    = ALU_OP_FUNCT;
                ctrl_raw.rs1_used  = 1'b1;
            end
            OPC_STORE: begin
                ctrl_raw.mem_write = 1'b1;
                ctrl_raw.alu_src   = 1'b1;
                ctrl_raw.imm_src   = IMM_S;
                ctrl_raw.rs1_used  = 1'b1;
                ctrl_raw.rs2_used  = 1'b1;
            end
            OPC_BRANCH: begin
                ctrl_raw.branch   = 1'b1;
                ctrl_raw.imm_src  = IMM_B;
                ctrl_raw.alu_op   = ALU_OP_BR;
                ctrl_raw.rs1_used = 1'b1;
                ctrl_raw.rs2_used = 1'b1;
            end
            OPC_JALR: begin
                ctrl_raw.jump       = 1'b1;
                ctrl_raw.jalr       = 1'b1;
                ctrl_raw.result_src = RES_PC4;
                ctrl_raw.alu_src    = 1'b1;
                ctrl_raw.imm_src    = IMM_I;
                ctrl_raw.reg_write  = 1'b1;
                ctrl_raw.rs1_used   = 1'b1;
            end
            OPC_JAL: begin
                ctrl_raw.jump       = 1'b1;
                ctrl_raw.result_src = RES_PC4;
                ctrl_raw.alu_src    = 1'b1;
                ctrl_raw.imm_src    = IMM_J;
                ctrl_raw.reg_write  = 1'b1;
            end
            OPC_LUI: begin
                ctrl_raw.alu_src   = 1'b1;
                ctrl_raw.imm_src   = IMM_U;
                ctrl_raw.reg_write = 1'b1;
                ctrl_raw.alu_op    = ALU_OP_LUI;
            end
            OPC_AUIPC: begin
                ctrl_raw.alu_src   = 1'b1;
                ctrl_raw.imm_src   = IMM_U;
                ctrl_raw.reg_write = 1'b1;
                ctrl_raw.op1_pc    = 1'b1;
            end
            default: bad = (instr != '0);
        endcase
    end

    // Illegal words never carry side effects downstream: all enables cleared
    always_comb begin
        ctrl = ctrl_raw;
        if (bad) begin
            ctrl = '0;
`ifdef CU_ILLEGAL_TRAP_EN
            ctrl.illegal = 1'b1;
`endif
        end
    end
endmodule

// File: rtl/decode_stage_ctrl.sv
// Registered decode stage with divider-occupancy tracking; CU_ILLEGAL_TRAP_EN selects trap vs NOP for illegal words.
// Latency: 1 cycle accept -> out_valid, 1 instr/cycle when unstalled.
// Backpressure: holds output under ~out_ready; M ops also stall while a DIV/REM occupies the divider.
module decode_stage_ctrl
    import cu_pkg::*;
#(
    parameter int XLEN       = 32,   // must match the interface XLEN
    parameter int M_EXT      = 1,
    parameter int DIV_CYCLES = 34    // >= 2
) (
    input  logic clk,
    input  logic rst_n,
    decode_stage_ctrl_if.slave bus
);
    localparam int              CW        = $clog2(DIV_CYCLES);
    localparam logic [CW-1:0]   BUSY_LOAD = CW'(DIV_CYCLES - 1);

    ctrl_t           dec_ctrl;
    logic            dec_m, m_block, in_ready, accept, div_handoff;

    logic            out_valid_q, out_valid_d;
    ctrl_t           out_ctrl_q, out_ctrl_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic [4:0]      out_rd_q, out_rd_d, out_rs1_q, out_rs1_d, out_rs2_q, out_rs2_d;
    logic [2:0]      out_funct3_q, out_funct3_d;
    logic [CW-1:0]   busy_cnt_q, busy_cnt_d;

    decode_ctrl_comb #(.M_EXT(M_EXT)) u_dec (
        .instr (bus.in_instr),
        .ctrl  (dec_ctrl)
    );

    // Handshake: a DIV sitting in the output register counts as occupying the divider already
    always_comb begin
        dec_m       = is_m_op(dec_ctrl);
        m_block     = (busy_cnt_q != '0) | (out_valid_q & out_ctrl_q.div_en);
        in_ready    = (~out_valid_q | bus.out_ready) & ~(dec_m & m_block);
        accept      = bus.in_valid & in_ready & ~bus.flush;
        div_handoff = out_valid_q & bus.out_ready & out_ctrl_q.div_en & ~bus.flush;
    end

    // Output register: load on accept, drain on consume/flush, otherwise hold stable
    always_comb begin
        out_valid_d  = out_valid_q;
        out_ctrl_d   = out_ctrl_q;
        out_pc_d     = out_pc_q;
        out_rd_d     = out_rd_q;
        out_rs1_d    = out_rs1_q;
        out_rs2_d    = out_rs2_q;
        out_funct3_d = out_funct3_q;
        if (accept) begin
            out_valid_d  = 1'b1;
            out_ctrl_d   = dec_ctrl;
            out_pc_d     = bus.in_pc;
            out_rd_d     = bus.in_instr[11:7];
            out_rs1_d    = dec_ctrl.rs1_used ? bus.in_instr[19:15] : 5'd0;
            out_rs2_d    = dec_ctrl.rs2_used ? bus.in_instr[24:20] : 5'd0;
            out_funct3_d = bus.in_instr[14:12];
        end else if (bus.out_ready | bus.flush) begin
            out_valid_d = 1'b0;
        end
    end

    // Divider occupancy: starts on a real DIV handoff, counts down to idle
    always_comb begin
        busy_cnt_d = busy_cnt_q;
        if (div_handoff) begin
            busy_cnt_d = BUSY_LOAD;
        end else if (busy_cnt_q != '0) begin
            busy_cnt_d = busy_cnt_q - CW'(1);
        end
    end

    // State registers; reset drops any divider tracking along with the pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_ctrl_q   <= '0;
            out_pc_q     <= '0;
            out_rd_q     <= '0;
            out_rs1_q    <= '0;
            out_rs2_q    <= '0;
            out_funct3_q <= '0;
            busy_cnt_q   <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_ctrl_q   <= out_ctrl_d;
            out_pc_q     <= out_pc_d;
            out_rd_q     <= out_rd_d;
            out_rs1_q    <= out_rs1_d;
            out_rs2_q    <= out_rs2_d;
            out_funct3_q <= out_funct3_d;
            busy_cnt_q   <= busy_cnt_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_ctrl   = out_ctrl_q;
    assign bus.out_pc     = out_pc_q;
    assign bus.out_rd     = out_rd_q;
    assign bus.out_rs1    = out_rs1_q;
    assign bus.out_rs2    = out_rs2_q;
    assign bus.out_funct3 = out_funct3_q;
    assign bus.div_busy   = (busy_cnt_q != '0);
endmodule

// File: tb/tb_decode_stage_ctrl.sv
// Bench for decode_stage_ctrl: directed vectors, per-cycle scoreboard against a timestamp-based model.
// Latency: n/a.
// Backpressure: exercised via out_ready stalls, flush and divider occupancy.
module tb_decode_stage_ctrl;
    import cu_pkg::*;

    localparam int DIVC = 34;
    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_ADD2 = 32'h00308233;
    localparam logic [31:0] I_DIV  = 32'h0220C1B3;
    localparam logic [31:0] I_MUL  = 32'h022081B3;
    localparam logic [31:0] I_JAL  = 32'h008000EF;
    localparam logic [31:0] I_LW   = 32'h0000A103;
    localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decode_stage_ctrl_if #(.XLEN(32)) bus ();
    decode_stage_ctrl_if #(.XLEN(32)) bus0 ();

    decode_stage_ctrl #(.XLEN(32), .M_EXT(1), .DIV_CYCLES(DIVC)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
    decode_stage_ctrl #(.XLEN(32), .M_EXT(0), .DIV_CYCLES(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Reference decode straight from the opcode table
    function automatic ctrl_t ref_ctrl(logic [31:0] i, bit mext);
        ctrl_t c;
        bit bad;
        logic [6:0] f7;
        c = '0; bad = 0; f7 = i[31:25];
        case (i[6:0])
            7'd51: begin
                c.reg_write = 1; c.rs1_used = 1; c.rs2_used = 1;
                if (mext && f7 == 7'h01) begin
                    c.alu_op = i[14] ? 3'd5 : 3'd4;
                    c.div_en = i[14];
                    c.mul_en = !i[14];
                end else if (f7 == 7'h00 || f7 == 7'h20) c.alu_op = 3'd2;
                else bad = 1;
            end
            7'd3:   begin c.result_src = 2'd1; c.alu_src = 1; c.reg_write = 1; c.rs1_used = 1; end
            7'd19:  begin c.alu_src = 1; c.reg_write = 1; c.alu_op = 3'd2; c.rs1_used = 1; end
            7'd35:  begin c.mem_write = 1; c.alu_src = 1; c.imm_src = 3'd1; c.rs1_used = 1; c.rs2_used = 1; end
            7'd99:  begin c.branch = 1; c.imm_src = 3'd2; c.alu_op = 3'd1; c.rs1_used = 1; c.rs2_used = 1; end
            7'd103: begin c.jump = 1; c.jalr = 1; c.result_src = 2'd2; c.alu_src = 1; c.reg_write = 1; c.rs1_used = 1; end
            7'd111: begin c.jump = 1; c.result_src = 2'd2; c.alu_src = 1; c.imm_src = 3'd3; c.reg_write = 1; end
            7'd55:  begin c.alu_src = 1; c.imm_src = 3'd4; c.reg_write = 1; c.alu_op = 3'd3; end
            7'd23:  begin c.alu_src = 1; c.imm_src = 3'd4; c.reg_write = 1; c.op1_pc = 1; end
            default: bad = (i != 32'd0);
        endcase
        if (bad) begin
            c = '0;
`ifdef CU_ILLEGAL_TRAP_EN
            c.illegal = 1;
`endif
        end
        return c;
    endfunction

    // Model: one held entry plus the cycle stamp of the last divider handoff
    bit          m_vld   = 0;
    logic [31:0] m_instr = '0;
    logic [31:0] m_pc    = '0;
    int          cyc     = 0;
    int          hcyc    = -1000;
    ctrl_t       mc, ic;
    bit          m_busy, m_blk, m_rdy;

    always @(negedge clk) begin : scoreboard
        if (!rst_n) begin
            chk("sb_rst_out_valid", 32'(bus.out_valid), 32'd0);
            chk("sb_rst_div_busy", 32'(bus.div_busy), 32'd0);
            m_vld = 0;
            hcyc  = -1000;
        end else begin
            m_busy = (cyc - hcyc >= 1) && (cyc - hcyc <= DIVC - 1);
            mc     = ref_ctrl(m_instr, 1);
            ic     = ref_ctrl(bus.in_instr, 1);
            m_blk  = m_busy || (m_vld && mc.div_en);
            m_rdy  = (!m_vld || bus.out_ready) && !((ic.mul_en || ic.div_en) && m_blk);
            chk("sb_in_ready", 32'(bus.in_ready), 32'(m_rdy));
            chk("sb_out_valid", 32'(bus.out_valid), 32'(m_vld));
            chk("sb_div_busy", 32'(bus.div_busy), 32'(m_busy));
            if (m_vld) begin
                chk("sb_out_pc", bus.out_pc, m_pc);
                chk("sb_out_rd", 32'(bus.out_rd), 32'(m_instr[11:7]));
                chk("sb_out_rs1", 32'(bus.out_rs1), mc.rs1_used ? 32'(m_instr[19:15]) : 32'd0);
                chk("sb_out_rs2", 32'(bus.out_rs2), mc.rs2_used ? 32'(m_instr[24:20]) : 32'd0);
                chk("sb_out_funct3", 32'(bus.out_funct3), 32'(m_instr[14:12]));
                chk("sb_out_ctrl", 32'(bus.out_ctrl), 32'(mc));
            end
            if (m_vld && bus.out_ready && mc.div_en && !bus.flush) hcyc = cyc;
            if (bus.in_valid && m_rdy && !bus.flush) begin
                m_vld = 1; m_instr = bus.in_instr; m_pc = bus.in_pc;
            end else if (bus.out_ready || bus.flush) begin
                m_vld = 0;
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Present one instruction until accepted; reports cycles spent waiting
    task automatic send(input logic [31:0] ins, input logic [31:0] pc, output int waits);
        bit done;
        done = 0; waits = 0;
        bus.in_valid = 1; bus.in_instr = ins; bus.in_pc = pc;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (bus.in_ready && !bus.flush) done = 1;
            else waits++;
            step();
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: instr 0x%0h not accepted within 200 cycles", ins);
        end
        bus.in_valid = 0; bus.in_instr = '0;
    endtask

    initial begin : main
        int w, cnt;
        ctrl_t e;
        bus.in_valid = 0; bus.in_instr = '0; bus.in_pc = '0; bus.flush = 0; bus.out_ready = 0;
        bus0.in_valid = 0; bus0.in_instr = '0; bus0.in_pc = '0; bus0.flush = 0; bus0.out_ready = 0;
        e = '0;
`ifdef CU_ILLEGAL_TRAP_EN
        e.illegal = 1;
`endif

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_ctrl", 32'(bus.out_ctrl), 32'd0);
        chk("rst_out_pc", bus.out_pc, 32'd0);
        chk("rst_out_rd", 32'(bus.out_rd), 32'd0);
        chk("rst_div_busy", 32'(bus.div_busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1; bus.out_ready = 1; bus0.out_ready = 1;

        // ADD: one-cycle latency, fields
        send(I_ADD, 32'h100, w);
        chk("add_wait", 32'(w), 32'd0);
        chk("add_valid", 32'(bus.out_valid), 32'd1);
        chk("add_alu_op", 32'(bus.out_ctrl.alu_op), 32'd2);
        chk("add_reg_write", 32'(bus.out_ctrl.reg_write), 32'd1);
        chk("add_rd", 32'(bus.out_rd), 32'd3);
        chk("add_rs1", 32'(bus.out_rs1), 32'd1);
        chk("add_rs2", 32'(bus.out_rs2), 32'd2);
        chk("add_pc", bus.out_pc, 32'h100);

        // DIV handoff then MUL: blocked in handoff cycle plus DIV_CYCLES-1 busy cycles
        send(I_DIV, 32'h104, w);
        chk("div_div_en", 32'(bus.out_ctrl.div_en), 32'd1);
        chk("div_alu_op", 32'(bus.out_ctrl.alu_op), 32'd5);
        send(I_MUL, 32'h108, w);
        chk("mul_stall_cycles", 32'(w), 32'(DIVC));
        chk("mul_mul_en", 32'(bus.out_ctrl.mul_en), 32'd1);
        chk("mul_alu_op", 32'(bus.out_ctrl.alu_op), 32'd4);
        step();

        // DIV then ADD: no stall; divider busy for DIV_CYCLES-1 cycles
        send(I_DIV, 32'h10C, w);
        send(I_ADD, 32'h110, w);
        chk("add_after_div_wait", 32'(w), 32'd0);
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.div_busy) cnt++;
            else k = 100;
            step();
        end
        chk("div_busy_cycles", 32'(cnt), 32'(DIVC - 1));

        // LW held under 5 stall cycles, then back-to-back resume
        send(I_LW, 32'h200, w);
        bus.out_ready = 0;
        bus.in_valid = 1; bus.in_instr = I_ADD; bus.in_pc = 32'h204;
        @(negedge clk);
        chk("lw_result_src", 32'(bus.out_ctrl.result_src), 32'd1);
        chk("lw_alu_src", 32'(bus.out_ctrl.alu_src), 32'd1);
        chk("lw_funct3", 32'(bus.out_funct3), 32'd2);
        chk("lw_rs2_forced", 32'(bus.out_rs2), 32'd0);
        step();
        repeat (4) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
            chk("stall_pc", bus.out_pc, 32'h200);
            chk("stall_rd", 32'(bus.out_rd), 32'd2);
            step();
        end
        bus.out_ready = 1;
        send(I_ADD, 32'h204, w);
        chk("resume_wait_a", 32'(w), 32'd0);
        send(I_ADD2, 32'h208, w);
        chk("resume_wait_b", 32'(w), 32'd0);
        chk("resume_pc", bus.out_pc, 32'h208);
        step();

        // Flush JAL under stall with a same-cycle incoming instruction
        bus.out_ready = 0;
        send(I_JAL, 32'h300, w);
        bus.flush = 1; bus.in_valid = 1; bus.in_instr = I_ADD; bus.in_pc = 32'h304;
        @(negedge clk);
        chk("jal_jump", 32'(bus.out_ctrl.jump), 32'd1);
        chk("jal_result_src", 32'(bus.out_ctrl.result_src), 32'd2);
        chk("jal_imm_src", 32'(bus.out_ctrl.imm_src), 32'd3);
        chk("jal_rd", 32'(bus.out_rd), 32'd1);
        chk("jal_rs1_forced", 32'(bus.out_rs1), 32'd0);
        step();
        bus.flush = 0; bus.in_valid = 0; bus.in_instr = '0;
        @(negedge clk);
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        step();
        bus.out_ready = 1;

        // Flushed DIV must not occupy the divider
        send(I_DIV, 32'h310, w);
        bus.flush = 1;
        step();
        bus.flush = 0;
        @(negedge clk);
        chk("flush_div_busy", 32'(bus.div_busy), 32'd0);
        chk("flush_div_valid", 32'(bus.out_valid), 32'd0);
        step();

        // Illegal word and NOP bubble
        send(I_BAD, 32'h400, w);
        chk("illegal_ctrl", 32'(bus.out_ctrl), 32'(e));
        send(32'd0, 32'h404, w);
        chk("nop_valid", 32'(bus.out_valid), 32'd1);
        chk("nop_ctrl", 32'(bus.out_ctrl), 32'd0);
        step();

        // M_EXT=0 instance: MUL/DIV are illegal and never M-blocked
        bus0.in_valid = 1; bus0.in_instr = I_MUL; bus0.in_pc = 32'h500;
        @(negedge clk);
        chk("m0_mul_in_ready", 32'(bus0.in_ready), 32'd1);
        step();
        bus0.in_instr = I_DIV; bus0.in_pc = 32'h504;
        @(negedge clk);
        chk("m0_mul_valid", 32'(bus0.out_valid), 32'd1);
        chk("m0_mul_ctrl", 32'(bus0.out_ctrl), 32'(e));
        chk("m0_div_in_ready", 32'(bus0.in_ready), 32'd1);
        step();
        bus0.in_valid = 0; bus0.in_instr = '0;
        @(negedge clk);
        chk("m0_div_ctrl", 32'(bus0.out_ctrl), 32'(e));
        chk("m0_div_busy", 32'(bus0.div_busy), 32'd0);
        step();

        // Reset during a divider stall clears everything immediately
        send(I_DIV, 32'h600, w);
        bus.in_valid = 1; bus.in_instr = I_MUL; bus.in_pc = 32'h604;
        repeat (3) step();
        @(negedge clk);
        chk("pre_rst_div_busy", 32'(bus.div_busy), 32'd1);
        chk("pre_rst_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        rst_n = 0;
        #1;
        chk("mid_rst_div_busy", 32'(bus.div_busy), 32'd0);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        step();
        rst_n = 1;
        send(I_MUL, 32'h604, w);
        chk("post_rst_mul_wait", 32'(w), 32'd0);
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
